// File: rtl/maxpool_relu_2x2_pkg.sv
// Shared CNN feature-map constants used by the conv and pooling stages.
package maxpool_relu_2x2_pkg;

    localparam int CNN_WIDTH    = 24;
    localparam int CNN_HEIGHT   = 24;
    localparam int CNN_DATA_BIT = 12;

    function automatic int half_dim(input int n);
        return n / 2;
    endfunction

    localparam int CNN_POOL_WIDTH  = half_dim(CNN_WIDTH);
    localparam int CNN_POOL_HEIGHT = half_dim(CNN_HEIGHT);

endpackage

// File: rtl/maxpool_relu_2x2_ch.sv
// One pooling channel: horizontal pair latch, half-width line buffer,
// signed 2x2 max and ReLU with a registered output.
module maxpool_ch
    import maxpool_relu_2x2_pkg::*;
#(
    parameter int DATA_BIT = CNN_DATA_BIT,
    parameter int LB_DEPTH = CNN_POOL_WIDTH,
    parameter int AW       = 4
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic                       col_odd,
    input  logic                       row_odd,
    input  logic [AW-1:0]              lb_addr,
    input  logic signed [DATA_BIT-1:0] pix_in,
    output logic [DATA_BIT-1:0]        pool_out
);

    function automatic logic signed [DATA_BIT-1:0] smax(
        input logic signed [DATA_BIT-1:0] a,
        input logic signed [DATA_BIT-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic signed [DATA_BIT-1:0] latch_r;
    logic signed [DATA_BIT-1:0] lbuf_r [LB_DEPTH];
    logic signed [DATA_BIT-1:0] hmax_s;
    logic signed [DATA_BIT-1:0] lb_rd_s;
    logic signed [DATA_BIT-1:0] pmax_s;
    logic signed [DATA_BIT-1:0] relu_s;
    logic        [DATA_BIT-1:0] pool_out_r;

    // Horizontal and vertical max, then clamp negatives to zero
    always_comb begin
        hmax_s  = smax(latch_r, pix_in);
        lb_rd_s = lbuf_r[lb_addr];
        pmax_s  = smax(lb_rd_s, hmax_s);
        if (pmax_s[DATA_BIT-1]) begin
            relu_s = {DATA_BIT{1'b0}};
        end else begin
            relu_s = pmax_s;
        end
    end

    // Even-column sample latch
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_r <= {DATA_BIT{1'b0}};
        end else if (valid_in && !col_odd) begin
            latch_r <= pix_in;
        end
    end

    // Line buffer is written before it is read in every frame, so it has no reset
    always_ff @(posedge clk) begin
        if (valid_in && col_odd && !row_odd) begin
            lbuf_r[lb_addr] <= hmax_s;
        end
    end

    // Output register holds its value between windows
    always_ff @(posedge clk) begin
        if (rst) begin
            pool_out_r <= {DATA_BIT{1'b0}};
        end else if (valid_in && col_odd && row_odd) begin
            pool_out_r <= relu_s;
        end
    end

    assign pool_out = pool_out_r;

endmodule

// File: rtl/maxpool_relu_2x2.sv
// 2x2 stride-2 max pooling with ReLU over three conv channels in lock-step.
// Shared raster counters drive three identical per-channel pooling slices.
module maxpool_relu_2x2
    import maxpool_relu_2x2_pkg::*;
#(
    parameter int WIDTH    = CNN_WIDTH,
    parameter int HEIGHT   = CNN_HEIGHT,
    parameter int DATA_BIT = CNN_DATA_BIT
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic signed [DATA_BIT-1:0] conv_in_1,
    input  logic signed [DATA_BIT-1:0] conv_in_2,
    input  logic signed [DATA_BIT-1:0] conv_in_3,
    output logic [DATA_BIT-1:0]        pool_out_1,
    output logic [DATA_BIT-1:0]        pool_out_2,
    output logic [DATA_BIT-1:0]        pool_out_3,
    output logic                       valid_out
);

    localparam int CW       = (WIDTH  > 1) ? $clog2(WIDTH)     : 1;
    localparam int RW       = (HEIGHT > 1) ? $clog2(HEIGHT)    : 1;
    localparam int AW       = (WIDTH  > 2) ? $clog2(WIDTH / 2) : 1;
    localparam int LB_DEPTH = half_dim(WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic          valid_out_r;
    logic          col_odd_s;
    logic          row_odd_s;
    logic          fire_s;
    logic [AW-1:0] lb_addr_s;

    // Decode window position from the raster counters
    always_comb begin
        col_odd_s = col_r[0];
        row_odd_s = row_r[0];
        lb_addr_s = AW'(col_r >> 1);
        fire_s    = valid_in & col_odd_s & row_odd_s;
    end

    // Raster counters advance only on valid pixels; frames wrap with no gap
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r       <= {CW{1'b0}};
            row_r       <= {RW{1'b0}};
            valid_out_r <= 1'b0;
        end else begin
            valid_out_r <= fire_s;
            if (valid_in) begin
                if (col_r == COL_LAST) begin
                    col_r <= {CW{1'b0}};
                    if (row_r == ROW_LAST) begin
                        row_r <= {RW{1'b0}};
                    end else begin
                        row_r <= row_r + RW'(1);
                    end
                end else begin
                    col_r <= col_r + CW'(1);
                end
            end
        end
    end

    assign valid_out = valid_out_r;

    maxpool_ch #(.DATA_BIT(DATA_BIT), .LB_DEPTH(LB_DEPTH), .AW(AW)) u_ch1 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .col_odd(col_odd_s),
        .row_odd(row_odd_s), .lb_addr(lb_addr_s), .pix_in(conv_in_1), .pool_out(pool_out_1)
    );

    maxpool_ch #(.DATA_BIT(DATA_BIT), .LB_DEPTH(LB_DEPTH), .AW(AW)) u_ch2 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .col_odd(col_odd_s),
        .row_odd(row_odd_s), .lb_addr(lb_addr_s), .pix_in(conv_in_2), .pool_out(pool_out_2)
    );

    maxpool_ch #(.DATA_BIT(DATA_BIT), .LB_DEPTH(LB_DEPTH), .AW(AW)) u_ch3 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .col_odd(col_odd_s),
        .row_odd(row_odd_s), .lb_addr(lb_addr_s), .pix_in(conv_in_3), .pool_out(pool_out_3)
    );

endmodule
